// File: rtl/add_sub_accumulator_if.sv
// add_sub_accumulator_if: start/term/result stream bundle for the accumulator
interface add_sub_accumulator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
);
    logic                  start;
    logic [CNT_WIDTH-1:0]  n_terms;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_overflow;
    logic                  busy;

    modport master (
        output start, n_terms, in_valid, in_data, in_sub, out_ready,
        input  in_ready, out_valid, out_data, out_overflow, busy
    );

    modport slave (
        input  start, n_terms, in_valid, in_data, in_sub, out_ready,
        output in_ready, out_valid, out_data, out_overflow, busy
    );
endinterface

// File: rtl/add_sub_accumulator.sv
// add_sub_accumulator: burst add/subtract accumulator on a 4-bit-group CLA; ADD_SUB_ACC_SAT_EN enables saturation
module add_sub_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input logic clk,
    input logic rst,
    add_sub_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] acc, b, g, p, sum, nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  sticky, in_ready, out_valid, busy, ovf, cy;
    logic [3:0]            k;

    assign b = bus.in_sub ? ~bus.in_data : bus.in_data;
    assign g = acc & b;
    assign p = acc ^ b;

    // carry-look-ahead within each 4-bit group, groups chained by their carry-out
    always_comb begin
        cy = bus.in_sub;
        k = '0;
        sum = '0;
        for (int i = 0; i < DATA_WIDTH; i += 4) begin
            k[0] = cy;
            k[1] = g[i] | (p[i] & k[0]);
            k[2] = g[i+1] | (p[i+1] & g[i]) | (p[i+1] & p[i] & k[0]);
            k[3] = g[i+2] | (p[i+2] & g[i+1]) | (p[i+2] & p[i+1] & g[i]) | (p[i+2] & p[i+1] & p[i] & k[0]);
            cy = g[i+3] | (p[i+3] & g[i+2]) | (p[i+3] & p[i+2] & g[i+1])
               | (p[i+3] & p[i+2] & p[i+1] & g[i]) | (p[i+3] & p[i+2] & p[i+1] & p[i] & k[0]);
            sum[i +: 4] = p[i +: 4] ^ k;
        end
    end

    // signed overflow: both operands share a sign the result does not
    assign ovf = (acc[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != acc[DATA_WIDTH-1]);

`ifdef ADD_SUB_ACC_SAT_EN
    // overflow direction follows the sign of acc: negative acc can only overflow downward
    assign nxt = !ovf ? sum : acc[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    assign nxt = sum;
`endif

    // burst control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cnt       <= bus.n_terms;
                    acc       <= '0;
                    sticky    <= 1'b0;
                    busy      <= 1'b1;
                    state     <= (bus.n_terms == '0) ? DONE : ACCUM;
                    in_ready  <= (bus.n_terms != '0);
                    out_valid <= (bus.n_terms == '0);
                end
                ACCUM: if (bus.in_valid) begin
                    acc    <= nxt;
                    cnt    <= cnt - 1'b1;
                    sticky <= sticky | ovf;
                    if (cnt == CNT_WIDTH'(1)) begin
                        state     <= DONE;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.busy         = busy;
    assign bus.out_data     = acc;
    assign bus.out_overflow = sticky;
endmodule

// File: tb/tb_add_sub_accumulator.sv
// tb_add_sub_accumulator: directed and random bursts checked against an integer-arithmetic model
module tb_add_sub_accumulator;
    localparam int DW  = 16;
    localparam int CW  = 8;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] td[$];
    bit            ts[$];

    add_sub_accumulator_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    add_sub_accumulator #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exact integer sum per step, then wrap or clamp into the signed range
    task automatic model(output logic [DW-1:0] res, output bit ov);
        int s = 0;
        ov = 0;
        for (int i = 0; i < td.size(); i++) begin
            int d = $signed(td[i]);
            s = ts[i] ? s - d : s + d;
            if (s > MAXV || s < MINV) begin
                ov = 1;
`ifdef ADD_SUB_ACC_SAT_EN
                s = (s > MAXV) ? MAXV : MINV;
`else
                s = (s > MAXV) ? s - (1 << DW) : s + (1 << DW);
`endif
            end
        end
        res = DW'(s);
    endtask

    task automatic burst(input string tag, input bit gaps, input bit spam, input int hold);
        logic [DW-1:0] er;
        bit            eo;
        int            n = td.size();
        int            i = 0;
        int            cyc = 0;
        bit            acc;
        model(er, eo);
        bus.start = 1'b1;
        bus.n_terms = CW'(n);
        tick();
        bus.start = 1'b0;
        check({tag, ".busy"}, 32'(bus.busy), 1);
        check({tag, ".ready"}, 32'(bus.in_ready), 32'(n != 0));
        while (i < n && cyc < 200) begin
            bus.in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            bus.in_data  = td[i];
            bus.in_sub   = ts[i];
            bus.start    = spam && (cyc % 3 == 1);
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) i++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        check({tag, ".consumed"}, 32'(i), 32'(n));
        for (int h = 0; h <= hold; h++) begin
            check({tag, ".valid"}, 32'(bus.out_valid), 1);
            check({tag, ".data"}, 32'(bus.out_data), 32'(er));
            check({tag, ".ovf"}, 32'(bus.out_overflow), 32'(eo));
            check({tag, ".noready"}, 32'(bus.in_ready), 0);
            if (h < hold) tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".idle_valid"}, 32'(bus.out_valid), 0);
        check({tag, ".idle_busy"}, 32'(bus.busy), 0);
        td.delete();
        ts.delete();
    endtask

    task automatic all_zero(input string tag);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 0);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 0);
        check({tag, ".out_data"}, 32'(bus.out_data), 0);
        check({tag, ".out_ovf"}, 32'(bus.out_overflow), 0);
        check({tag, ".busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.n_terms = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_sub = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        all_zero("reset");
        rst = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        all_zero("idle_ignore");

        td = '{16'd100, 16'd200, 16'd50}; ts = '{0, 0, 1};
        burst("basic", 0, 0, 0);
        td = '{16'd30000, 16'd10000}; ts = '{0, 0};
        burst("posovf", 0, 0, 0);
        td = '{16'h8000}; ts = '{1};
        burst("subneg", 0, 0, 0);
        td = '{16'hFFFF, 16'h8000}; ts = '{0, 1};
        burst("m1subneg", 0, 0, 0);
        td = '{16'd5, 16'hFFFD, 16'd9, 16'd1}; ts = '{0, 0, 1, 0};
        burst("gaps", 1, 1, 0);
        td = '{16'd1234, 16'd4321}; ts = '{1, 0};
        burst("hold", 0, 0, 5);
        burst("zero", 0, 0, 1);

        bus.start = 1'b1;
        bus.n_terms = 8'd5;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 16'd3;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        all_zero("midrst");
        rst = 1'b0;
        td = '{16'd7, 16'd8}; ts = '{0, 0};
        burst("after_rst", 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                td.push_back(DW'($urandom));
                ts.push_back(1'($urandom_range(0, 1)));
            end
            burst($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/add_sub_accumulator.md
# add_sub_accumulator

Sequential accumulation stage wrapped around the team's `Add_Sub` carry-look-ahead adder. It accepts a burst of N signed terms over a valid/ready stream and adds or subtracts each one into a running sum, one term per cycle. Each term drives the adder's `A`/`B`/`cin` inputs, and the block registers the adder's `result` and `overflow` outputs. The final sum is emitted on a valid/ready output port. The ODE-solver datapath uses it to form multi-term update sums.

## Interface
- `DATA_WIDTH`, 16: operand/sum width; must be a multiple of 4 (adder constraint).
- `CNT_WIDTH`, 8: width of the term counter; max burst = 2^CNT_WIDTH − 1.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a burst; sampled only in IDLE.
- `n_terms` in CNT_WIDTH: burst length, latched on accepted `start`.
- `in_valid` in 1: term present.
- `in_ready` out 1: block accepts term this cycle.
- `in_data` in DATA_WIDTH: signed term.
- `in_sub` in 1: 1 = subtract term, 0 = add.
- `out_valid` out 1: final sum available.
- `out_ready` in 1: consumer takes sum.
- `out_data` out DATA_WIDTH: signed final sum.
- `out_overflow` out 1: sticky; set if any step in the burst overflowed.
- `busy` out 1: high in ACCUM and DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: `in_ready`=0, `out_valid`=0. On `start`=1 the block latches `n_terms` into `cnt`, clears `acc` and the sticky flag, and goes to ACCUM. If `n_terms`=0 it goes directly to DONE with `acc`=0.
- ACCUM: `in_ready`=1. A term is accepted on `in_valid && in_ready`.
  - Adder drive: `A`=`acc`, `B`=`in_sub ? ~in_data : in_data`, `cin`=`in_sub`.
  - On acceptance, `acc` ← adder result (or saturated value, see Configuration) and `cnt` ← `cnt` − 1.
  - Sticky flag |= adder `overflow`.
  - When the accepted term is the last one (`cnt`=1), the next state is DONE.
- DONE: `out_valid`=1, `out_data`=`acc`, `out_overflow`=sticky flag. On `out_ready`=1 the output is consumed and the FSM returns to IDLE. Outputs stay stable until then.
- `start` outside IDLE is ignored, with no effect.
- `in_valid` outside ACCUM is ignored, and nothing is consumed.
- Arithmetic is two's complement, modulo 2^DATA_WIDTH, and the `Add_Sub` overflow rule applies. Subtracting the most negative value is handled correctly by the `~B`+`cin` form. Example: 0 − (−32768) is flagged as overflow.
- Reset (any state, including mid-burst) forces:
  - IDLE;
  - `acc`=0, `cnt`=0, sticky flag=0;
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `out_overflow`=0, `busy`=0.
  
  A partial burst is discarded.

## Timing
- `start` accepted at edge k → ACCUM (`in_ready`=1) from cycle k+1.
- Throughput: one term per cycle while `in_valid` is held high. Gaps (`in_valid`=0) stall without changing state.
- Last term accepted at edge m → `out_valid`=1 in cycle m+1 (1-cycle latency).
- `n_terms`=0: `out_valid`=1 one cycle after `start`.
- `out_ready` high while `out_valid`=1 at edge j → IDLE in cycle j+1. The next `start` can be accepted at edge j+1.
- Adder path is purely combinational within one cycle; no internal pipeline register.

## Configuration
- `ADD_SUB_ACC_SAT_EN` defined: on a step with overflow, `acc` is clamped.
  - Positive overflow clamps to 2^(DATA_WIDTH−1)−1 (0x7FFF).
  - Negative overflow clamps to −2^(DATA_WIDTH−1) (0x8000).
  - Accumulation continues from the clamped value, and the sticky flag still sets.
- Not defined: `acc` takes the wrapped adder result and the sticky flag sets; no clamping logic is present.

## Test plan
- `n_terms`=3, terms +100, +200, −50 (`in_sub`=1 on the third, data 50), no gaps → `out_data`=250, `out_overflow`=0, `out_valid` in the cycle after the third accept.
- `n_terms`=2, terms +30000 add, +10000 add → with SAT_EN: `out_data`=0x7FFF, `out_overflow`=1. Without SAT_EN: `out_data`=0x9C40 (−25536), `out_overflow`=1.
- `n_terms`=1, subtract −32768 from 0 → overflow=1; SAT_EN result 0x7FFF, otherwise 0x8000. Second burst: −1 − (−32768) → 0x7FFF, overflow=0.
- `n_terms`=4 with `in_valid` toggling 1,0,1,0,…, plus `start` pulses during ACCUM → exactly 4 terms consumed, extra `start` ignored, correct sum.
- `out_ready` held 0 for 5 cycles in DONE → `out_data`/`out_valid` stable. `n_terms`=0 burst → `out_data`=0 one cycle after `start`.
- `rst` asserted after 2 of 5 terms → next cycle all outputs 0 and IDLE. A new burst of 2 terms (7, 8) → `out_data`=15, `out_overflow`=0.
